// File: rtl/phase_mon_pkg.sv
// rtl/phase_mon_pkg.sv - shared state type and one-hot helper for the phase sequence monitor
package phase_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } phase_mon_state_t;

  // Callers zero-extend narrower vectors; extra zero bits never change the result.
  function automatic logic is_onehot(input logic [31:0] vec);
    return $countones(vec) == 1;
  endfunction

endpackage

// File: rtl/onehot_to_index.sv
// rtl/onehot_to_index.sv - combinational bit-position decoder with one-hot flag
module onehot_to_index
  import phase_mon_pkg::*;
#(
  parameter int DIVIDE_BY = 2
) (
  input  logic [DIVIDE_BY-1:0]         vec_i,
  output logic [$clog2(DIVIDE_BY)-1:0] pos_o,
  output logic                         onehot_o
);

  localparam int IDX_W = $clog2(DIVIDE_BY);

  // Highest set bit wins; pos is only trusted when onehot_o is high.
  always_comb begin
    pos_o = '0;
    for (int i = 0; i < DIVIDE_BY; i++) begin
      if (vec_i[i]) pos_o = IDX_W'(i);
    end
  end

  assign onehot_o = is_onehot(32'(vec_i));

endmodule

// File: rtl/phase_sequence_monitor.sv
// rtl/phase_sequence_monitor.sv - lock qualifier and decoder for the rotating one-hot phase vector
// Optional live error counter built only when PHASE_MON_ERR_COUNT_EN is defined.
module phase_sequence_monitor
  import phase_mon_pkg::*;
#(
  parameter int DIVIDE_BY   = 2,
  parameter int LOCK_CYCLES = 4,
  parameter int ERR_W       = 8
) (
  input  logic                         clkIn,
  input  logic                         rstN,
  input  logic [DIVIDE_BY-1:0]         phaseIn,
  output logic [$clog2(DIVIDE_BY)-1:0] phaseIdx,
  output logic                         phaseValid,
  output logic                         locked,
  output logic                         stepStrobe,
  output logic                         errPulse,
  output logic [ERR_W-1:0]             errCount
);

  localparam int IDX_W = $clog2(DIVIDE_BY);
  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  logic [DIVIDE_BY-1:0] cur_q, prev_q;
  logic [DIVIDE_BY-1:0] expected;
  phase_mon_state_t     state_q, state_d;
  logic [CNT_W-1:0]     good_cnt_q, good_cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 strobe_q, strobe_d;
  logic                 err_q, err_d;
  logic [IDX_W-1:0]     pos, idx_dec;
  logic                 onehot, is_zero, multi, good;

  onehot_to_index #(.DIVIDE_BY(DIVIDE_BY)) u_dec (
    .vec_i   (cur_q),
    .pos_o   (pos),
    .onehot_o(onehot)
  );

  // Phase 0 sits in the MSB, so the index counts down from the top bit.
  assign expected = {prev_q[0], prev_q[DIVIDE_BY-1:1]};
  assign good     = onehot && (cur_q == expected);
  assign is_zero  = (cur_q == '0);
  assign multi    = !onehot && !is_zero;
  assign idx_dec  = IDX_W'(DIVIDE_BY - 1) - pos;

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (onehot) begin
          state_d    = ACQUIRE;
          good_cnt_d = '0;
        end
      end
      ACQUIRE: begin
        if (multi) begin
          state_d = FAULT;
        end else if (is_zero) begin
          state_d    = IDLE;
          good_cnt_d = '0;
        end else if (good) begin
          if (good_cnt_q == CNT_LAST) state_d = LOCKED;
          else good_cnt_d = good_cnt_q + CNT_W'(1);
        end else begin
          good_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (!good) begin
          state_d = FAULT;
          err_d   = 1'b1;
        end
      end
      FAULT: begin
        if (onehot) begin
          state_d    = ACQUIRE;
          good_cnt_d = '0;
        end else if (is_zero) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    strobe_d = 1'b0;
    if (state_d == LOCKED) begin
      idx_d    = idx_dec;
      strobe_d = (idx_dec == '0);
    end
  end

  always_ff @(posedge clkIn) begin
    if (!rstN) begin
      cur_q      <= '0;
      prev_q     <= '0;
      state_q    <= IDLE;
      good_cnt_q <= '0;
      idx_q      <= '0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cur_q      <= phaseIn;
      prev_q     <= cur_q;
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      idx_q      <= idx_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
    end
  end

  assign phaseIdx   = idx_q;
  assign locked     = (state_q == LOCKED);
  assign phaseValid = (state_q == LOCKED);
  assign stepStrobe = strobe_q;
  assign errPulse   = err_q;

`ifdef PHASE_MON_ERR_COUNT_EN
  logic [ERR_W-1:0] err_cnt_q;

  // Counts in step with errPulse and sticks at all-ones until reset.
  always_ff @(posedge clkIn) begin
    if (!rstN) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end

  assign errCount = err_cnt_q;
`else
  assign errCount = '0;
`endif

endmodule

// File: tb/tb_phase_sequence_monitor.sv
// tb/tb_phase_sequence_monitor.sv - self-checking bench for phase_sequence_monitor
module tb_phase_sequence_monitor;

  localparam int N  = 4;
  localparam int LC = 4;
  localparam int EW = 8;
  localparam int ERR_MAX = (1 << EW) - 1;
  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCKED = 2, M_FAULT = 3;

  logic          clkIn = 1'b0;
  logic          rstN = 1'b0;
  logic [N-1:0]  phaseIn = '0;
  logic [1:0]    phaseIdx;
  logic          phaseValid, locked, stepStrobe, errPulse;
  logic [EW-1:0] errCount;

  phase_sequence_monitor #(.DIVIDE_BY(N), .LOCK_CYCLES(LC), .ERR_W(EW)) dut (
    .clkIn     (clkIn),
    .rstN      (rstN),
    .phaseIn   (phaseIn),
    .phaseIdx  (phaseIdx),
    .phaseValid(phaseValid),
    .locked    (locked),
    .stepStrobe(stepStrobe),
    .errPulse  (errPulse),
    .errCount  (errCount)
  );

  always #5 clkIn = ~clkIn;

  int checks = 0;
  int failures = 0;

  logic [N-1:0] m_cur = '0, m_prev = '0;
  int m_mode = M_IDLE, m_run = 0, m_idx = 0, m_errcnt = 0;
  bit m_locked = 0, m_strobe = 0, m_err = 0;

  function automatic int ones(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int bitpos(input logic [N-1:0] v);
    int p = 0;
    for (int i = 0; i < N; i++) if (v[i]) p = i;
    return p;
  endfunction

  function automatic logic [N-1:0] rot(input logic [N-1:0] v);
    return (v >> 1) | (v << (N - 1));
  endfunction

  function automatic int exp_cnt(input int c);
`ifdef PHASE_MON_ERR_COUNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  // Reference: acts on the previously sampled pair, then takes the new sample.
  task automatic model_edge(input logic [N-1:0] p, input logic r);
    int k;
    bit good;
    if (!r) begin
      m_cur = '0; m_prev = '0; m_mode = M_IDLE; m_run = 0; m_idx = 0;
      m_errcnt = 0; m_locked = 0; m_strobe = 0; m_err = 0;
    end else begin
      k = ones(m_cur);
      good = (k == 1) && (m_cur == rot(m_prev));
      m_err = 0;
      case (m_mode)
        M_IDLE: if (k == 1) begin m_mode = M_ACQ; m_run = 0; end
        M_ACQ: begin
          if (k > 1) m_mode = M_FAULT;
          else if (k == 0) begin m_mode = M_IDLE; m_run = 0; end
          else if (good) begin
            m_run++;
            if (m_run == LC) m_mode = M_LOCKED;
          end else m_run = 0;
        end
        M_LOCKED: if (!good) begin
          m_mode = M_FAULT;
          m_err = 1;
          if (m_errcnt < ERR_MAX) m_errcnt++;
        end
        default: begin
          if (k == 1) begin m_mode = M_ACQ; m_run = 0; end
          else if (k == 0) m_mode = M_IDLE;
        end
      endcase
      m_locked = (m_mode == M_LOCKED);
      m_strobe = 0;
      if (m_locked) begin
        m_idx = N - 1 - bitpos(m_cur);
        m_strobe = (m_idx == 0);
      end
      m_prev = m_cur;
      m_cur = p;
    end
  endtask

  task automatic tick(input logic [N-1:0] p, input logic r);
    phaseIn = p;
    rstN = r;
    @(posedge clkIn);
    model_edge(p, r);
    @(negedge clkIn);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_locked", int'(locked), int'(m_locked));
    chk("m_valid", int'(phaseValid), int'(m_locked));
    chk("m_idx", int'(phaseIdx), m_idx);
    chk("m_strobe", int'(stepStrobe), int'(m_strobe));
    chk("m_errpulse", int'(errPulse), int'(m_err));
    chk("m_errcount", int'(errCount), exp_cnt(m_errcnt));
  endtask

  typedef struct {
    logic [N-1:0] p;
    logic r;
    logic lk;
    int idx;
    logic st;
    logic ep;
    int ec;
  } vec_t;

  vec_t tbl[18];
  logic [N-1:0] rv;
  int n;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'b1000, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
    tbl[1]  = '{4'b0100, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
    tbl[2]  = '{4'b0010, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
    tbl[3]  = '{4'b0001, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
    tbl[4]  = '{4'b1000, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
    tbl[5]  = '{4'b0100, 1'b1, 1'b1, 0, 1'b1, 1'b0, 0};
    tbl[6]  = '{4'b0010, 1'b1, 1'b1, 1, 1'b0, 1'b0, 0};
    tbl[7]  = '{4'b0001, 1'b1, 1'b1, 2, 1'b0, 1'b0, 0};
    tbl[8]  = '{4'b1000, 1'b1, 1'b1, 3, 1'b0, 1'b0, 0};
    tbl[9]  = '{4'b0100, 1'b1, 1'b1, 0, 1'b1, 1'b0, 0};
    tbl[10] = '{4'b0110, 1'b1, 1'b1, 1, 1'b0, 1'b0, 0};
    tbl[11] = '{4'b0010, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1};
    tbl[12] = '{4'b0001, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1};
    tbl[13] = '{4'b1000, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1};
    tbl[14] = '{4'b0100, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1};
    tbl[15] = '{4'b0010, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1};
    tbl[16] = '{4'b0001, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1};
    tbl[17] = '{4'b1000, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1};

    tick('0, 1'b0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_valid", int'(phaseValid), 0);
    chk("reset_errcount", int'(errCount), 0);
    for (int i = 0; i < 10; i++) begin
      tick('0, 1'b1);
      chk("idle_locked", int'(locked), 0);
      chk("idle_valid", int'(phaseValid), 0);
      chk("idle_errcount", int'(errCount), 0);
    end

    for (int i = 0; i < 18; i++) begin
      tick(tbl[i].p, tbl[i].r);
      chk($sformatf("tbl%0d_locked", i), int'(locked), int'(tbl[i].lk));
      chk($sformatf("tbl%0d_valid", i), int'(phaseValid), int'(tbl[i].lk));
      chk($sformatf("tbl%0d_idx", i), int'(phaseIdx), tbl[i].idx);
      chk($sformatf("tbl%0d_strobe", i), int'(stepStrobe), int'(tbl[i].st));
      chk($sformatf("tbl%0d_errpulse", i), int'(errPulse), int'(tbl[i].ep));
      chk($sformatf("tbl%0d_errcount", i), int'(errCount), exp_cnt(tbl[i].ec));
    end

    // Skip a phase while locked: 1000 followed directly by 0010.
    tick(4'b0010, 1'b1);
    chk("skip_pre_idx", int'(phaseIdx), 0);
    chk("skip_pre_strobe", int'(stepStrobe), 1);
    tick(4'b0001, 1'b1);
    chk("skip_errpulse", int'(errPulse), 1);
    chk("skip_locked", int'(locked), 0);
    chk("skip_errcount", int'(errCount), exp_cnt(2));
    tick(4'b1000, 1'b1);
    chk("skip_pulse_once", int'(errPulse), 0);
    chk("skip_errcount_hold", int'(errCount), exp_cnt(2));
    check_model();

    rv = 4'b0100;
    for (int i = 0; i < 1500; i++) begin
      int u;
      u = $urandom_range(0, 99);
      if (u < 3) tick(rv, 1'b0);
      else if (u < 6) tick(N'($urandom_range(0, 15)), 1'b1);
      else begin
        if (u < 9) rv = rot(rv);
        tick(rv, 1'b1);
      end
      rv = rot(rv);
      check_model();
    end

    for (int f = 0; f < 300; f++) begin
      for (int j = 0; j < 8; j++) begin
        tick(rv, 1'b1);
        rv = rot(rv);
        check_model();
      end
      tick('0, 1'b1);
      check_model();
    end
    tick(rv, 1'b1);
    rv = rot(rv);
    chk("errcount_saturated", int'(errCount), exp_cnt(ERR_MAX));

    for (int j = 0; j < 8; j++) begin
      tick(rv, 1'b1);
      rv = rot(rv);
    end
    chk("prereset_locked", int'(locked), 1);
    tick(rv, 1'b0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_valid", int'(phaseValid), 0);
    chk("rst_idx", int'(phaseIdx), 0);
    chk("rst_strobe", int'(stepStrobe), 0);
    chk("rst_errpulse", int'(errPulse), 0);
    chk("rst_errcount", int'(errCount), 0);
    n = -1;
    for (int j = 1; j <= 20; j++) begin
      tick(rv, 1'b1);
      rv = rot(rv);
      if (locked && n < 0) n = j;
    end
    chk("relock_ticks", n, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
